// File: rtl/mem_pkg.sv
// Shared memory-interface types for the cache/memory subsystem.
// MInput/MOutput are sized by BLOCK_SIZE/ADDR_WIDTH below and must match main memory.
// Also holds the arbiter state and requester-ID types used by mem_arbiter.
package mem_pkg;

  localparam int BLOCK_SIZE = 128;
  localparam int ADDR_WIDTH = 32;

  // Request from a cache (or the arbiter) towards memory.
  typedef struct packed {
    logic                  Valid;
    logic                  Wen;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [BLOCK_SIZE-1:0] WriteD;
  } MInput;

  // Response from memory (or the arbiter) towards a cache.
  typedef struct packed {
    logic                  Ready;
    logic [BLOCK_SIZE-1:0] ReadD;
  } MOutput;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // One-hot requester ID.
  typedef logic [1:0] arb_id_t;
  localparam arb_id_t ARB_NONE   = 2'b00;
  localparam arb_id_t ARB_ICACHE = 2'b01;
  localparam arb_id_t ARB_DCACHE = 2'b10;

  // The requester that is not 'id' (used to hand priority to the other side).
  function automatic arb_id_t arb_other(input arb_id_t id);
    return (id == ARB_DCACHE) ? ARB_ICACHE : ARB_DCACHE;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner select for mem_arbiter.
// Optional macro MEM_ARB_RR_EN: when defined, a tie is broken by the round-robin
// pointer; otherwise the DCache always wins a tie.
module mem_arb_picker
  import mem_pkg::*;
(
  input  logic    icache_valid_i,
  input  logic    dcache_valid_i,
`ifdef MEM_ARB_RR_EN
  input  arb_id_t rr_ptr_i,
`endif
  output arb_id_t winner_o
);

  // Pick one requester; a lone requester always wins regardless of build.
  always_comb begin
    winner_o = ARB_NONE;
    if (icache_valid_i && dcache_valid_i) begin
`ifdef MEM_ARB_RR_EN
      winner_o = (rr_ptr_i == ARB_DCACHE) ? ARB_DCACHE : ARB_ICACHE;
`else
      winner_o = ARB_DCACHE;
`endif
    end else if (dcache_valid_i) begin
      winner_o = ARB_DCACHE;
    end else if (icache_valid_i) begin
      winner_o = ARB_ICACHE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing single-ported main memory between ICache and DCache.
// One memory transaction outstanding at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break instead of fixed DCache priority.
//
// Handshake: a requester raises Valid with stable fields and holds them until it
// sees its Resp.Ready high for one cycle, then drops Valid. Towards memory, Valid
// is a single-cycle pulse (ISSUE); memory answers with a registered Ready which is
// only honoured in WAIT. Requests are sampled only in IDLE.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  MInput   ICacheReq_i,
  output MOutput  ICacheResp_o,
  input  MInput   DCacheReq_i,
  output MOutput  DCacheResp_o,
  output MInput   MemReq_o,
  input  MOutput  MemResp_i,
  output arb_id_t Grant_o
);

  arb_state_t            state_q, state_d;
  arb_id_t               id_q, id_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;
  arb_id_t               pick;

  // ICache traffic is always forced to a read, so its Wen is intentionally unused.
  logic unused_icache_wen;
  assign unused_icache_wen = ICacheReq_i.Wen;

`ifdef MEM_ARB_RR_EN
  arb_id_t rr_q, rr_d;

  mem_arb_picker u_picker (
    .icache_valid_i (ICacheReq_i.Valid),
    .dcache_valid_i (DCacheReq_i.Valid),
    .rr_ptr_i       (rr_q),
    .winner_o       (pick)
  );

  // Round-robin pointer: holds the requester that wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= ARB_ICACHE;
    else        rr_q <= rr_d;
  end
`else
  mem_arb_picker u_picker (
    .icache_valid_i (ICacheReq_i.Valid),
    .dcache_valid_i (DCacheReq_i.Valid),
    .winner_o       (pick)
  );
`endif

  // State and latched-transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= ARB_NONE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, pulse in ISSUE, wait for memory, respond in DONE.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick != ARB_NONE) begin
          id_d    = pick;
          state_d = ISSUE;
          if (pick == ARB_DCACHE) begin
            wen_d   = DCacheReq_i.Wen;
            addr_d  = DCacheReq_i.Addr;
            wdata_d = DCacheReq_i.WriteD;
          end else begin
            wen_d   = 1'b0;
            addr_d  = ICacheReq_i.Addr;
            wdata_d = ICacheReq_i.WriteD;
          end
`ifdef MEM_ARB_RR_EN
          rr_d = arb_other(pick);
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (MemResp_i.Ready) begin
          rdata_d = MemResp_i.ReadD;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: everything derives from registered state only.
  always_comb begin
    MemReq_o     = '0;
    ICacheResp_o = '0;
    DCacheResp_o = '0;
    Grant_o      = (state_q == IDLE) ? ARB_NONE : id_q;
    if (state_q == ISSUE) begin
      MemReq_o.Valid  = 1'b1;
      MemReq_o.Wen    = wen_q;
      MemReq_o.Addr   = addr_q;
      MemReq_o.WriteD = wdata_q;
    end
    if (state_q == DONE) begin
      if (id_q == ARB_ICACHE) begin
        ICacheResp_o.Ready = 1'b1;
        ICacheResp_o.ReadD = rdata_q;
      end
      if (id_q == ARB_DCACHE) begin
        DCacheResp_o.Ready = 1'b1;
        DCacheResp_o.ReadD = rdata_q;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter sharing the single-ported main memory between the instruction cache and the data cache. It accepts block-granular requests in the mem_pkg MInput format from each cache, serialises them onto the one memory port, and routes the MOutput response back to the winning cache. It sits between the ICache/DCache miss logic and main memory. Only one memory transaction is outstanding at any time.

Parameters:
BLOCK_SIZE, 128, cache block width in bits; must match main memory.
ADDR_WIDTH, 32, byte-address width carried in MInput.Addr.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
ICacheReq_i  input  MInput (2+ADDR_WIDTH+BLOCK_SIZE = 162)  ICache request: Valid, Wen, Addr, WriteD.
ICacheResp_o  output  MOutput (1+BLOCK_SIZE = 129)  ICache response: Ready, ReadD.
DCacheReq_i  input  MInput (162)  DCache request.
DCacheResp_o  output  MOutput (129)  DCache response.
MemReq_o  output  MInput (162)  request to main memory.
MemResp_i  input  MOutput (129)  main memory response; Ready is registered, 1 cycle after a sampled Valid.
Grant_o  output  2  debug: 2'b01 ICache owns memory, 2'b10 DCache owns, 2'b00 idle.

Behaviour:
- Reset (async on rst_n low): state IDLE. MemReq_o all zero. Both Resp_o Ready=0, ReadD=0. Grant_o=0. Latched request cleared. Round-robin pointer = ICache.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- Requester contract: hold Valid and all fields stable until its Ready is seen high, then drop Valid on the next edge.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any Valid is high, pick a winner, latch its Addr/Wen/WriteD and its ID, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: MemReq_o.Valid=1 with the latched fields for exactly one cycle. Go to WAIT.
  - WAIT: MemReq_o.Valid=0, so memory never sees a duplicate request. When MemResp_i.Ready=1, latch ReadD and go to DONE.
  - DONE: winner's Resp_o.Ready=1 and ReadD=latched data for exactly one cycle. The loser's Ready stays 0. Go to IDLE.
- Latency: Valid sampled in IDLE at edge N gives Ready to the requester during cycle N+3. Back-to-back throughput is one transaction per 4 cycles.
- Write responses: Ready is returned as normal. ReadD is forwarded as-is and is don't-care to the requester.
- ICache requests always go to memory with Wen=0, whatever ICacheReq_i.Wen says.
- Arbitration happens only in IDLE.
  - Fixed priority: DCache wins when both requesters are valid.
  - A requester that loses keeps Valid asserted and is granted at the next IDLE.
- A Valid arriving during ISSUE/WAIT/DONE is not sampled until IDLE.
- MemResp_i.Ready is ignored outside WAIT.
- Reset mid-transaction: the FSM returns to IDLE and the in-flight response is dropped.
  - A stale memory Ready arriving after reset is ignored.
  - A write already issued to memory may still complete.
- Grant_o equals the latched winner ID in ISSUE/WAIT/DONE, and 0 in IDLE.

Optional Feature:
Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are valid in IDLE, the one not granted most recently wins; the pointer updates on entry to ISSUE. No starvation.
- Undefined: fixed DCache priority as above, with no pointer register. A continuously requesting DCache may starve the ICache.
- Single-requester behaviour is identical in both builds.

Decomposition:
- mem_pkg additions:
  - arb_state_t enum (IDLE, ISSUE, WAIT, DONE).
  - arb_id_t 2-bit one-hot requester ID, with constants ARB_NONE, ARB_ICACHE, ARB_DCACHE.
  - MInput/MOutput remain in mem_pkg, parameterised by BLOCK_SIZE.
- One sub-module, mem_arb_picker: purely combinational winner select.
  - Inputs: two Valids, plus the RR pointer when MEM_ARB_RR_EN is defined.
  - Output: arb_id_t.
  - Instantiated once; the FSM and datapath latches stay in mem_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT, then release → all outputs 0 and state IDLE. A MemResp_i.Ready=1 on the following cycle produces no requester Ready.
- Single ICache read: Addr=0x00010000, Valid at edge 0 → MemReq_o.Valid=1 for 1 cycle at cycle 1 with Wen=0. Memory returns ReadD=128'hDEADBEEF_… → ICacheResp_o.Ready=1 with that data in cycle 3 only; DCacheResp_o.Ready stays 0.
- DCache write: Wen=1, Addr=0x00010010, WriteD=128'h1234 → MemReq_o carries Wen=1, Addr=0x00010010, WriteD=128'h1234 for one cycle → DCacheResp_o.Ready pulses at cycle 3. A following read of 0x00010010 returns 128'h1234.
- Simultaneous requests, MEM_ARB_RR_EN undefined: both Valid at edge 0 → DCache served first (Ready at cycle 3), ICache served next (Ready at cycle 7). Grant_o sequence is 10, then 00, then 01.
- Simultaneous requests, MEM_ARB_RR_EN defined: both held continuously for 4 transactions → grants alternate. The first grant goes to ICache (pointer reset value); no requester waits more than 8 cycles.
- No duplicate issue: a requester holds Valid through WAIT/DONE → exactly one MemReq_o.Valid pulse per transaction. Check across 100 random back-to-back transactions.
